// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: owns the PC, issues in-order imem fetches and buffers words for ID.
// Define IFQ_BYPASS_EN to present a response to ID in its arrival cycle when the queue is empty.
//   state | meaning
//   RUN   | every returning word belongs to a live request
//   DRAIN | words requested before a redirect are still due and get dropped
module if_prefetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDR_W-1:0]        imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [ADDR_W-1:0]        id_npc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DISC_W = CNT_W + 4;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [DISC_W-1:0]   discard_q, discard_d;
  logic [PTR_W-1:0]    tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PTR_W-1:0]    q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CNT_W-1:0]    q_count_q, q_count_d;
  logic [31:0]         last_instr_q, last_instr_d;
  logic [ADDR_W-1:0]   last_npc_q, last_npc_d;

  logic [ADDR_W-1:0]   tag_mem_q   [DEPTH];
  logic [31:0]         instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]   npc_mem_q   [DEPTH];

  logic byp, req_fire, resp_live, q_push, q_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      discard_q    <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      q_wr_q       <= '0;
      q_rd_q       <= '0;
      q_count_q    <= '0;
      last_instr_q <= '0;
      last_npc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      q_wr_q       <= q_wr_d;
      q_rd_q       <= q_rd_d;
      q_count_q    <= q_count_d;
      last_instr_q <= last_instr_d;
      last_npc_q   <= last_npc_d;
      if (req_fire) tag_mem_q[tag_wr_q] <= pc_q;
      if (q_push) begin
        instr_mem_q[q_wr_q] <= imem_resp_data;
        npc_mem_q[q_wr_q]   <= tag_mem_q[tag_rd_q] + ADDR_W'(4);
      end
    end
  end

  // Outputs; reset low holds both handshakes off.
  always_comb begin
`ifdef IFQ_BYPASS_EN
    byp = reset && (q_count_q == '0) && (state_q == RUN) && imem_resp_valid && !redirect_valid;
`else
    byp = 1'b0;
`endif
    imem_req_valid = reset && !redirect_valid
                     && (({1'b0, inflight_q} + {1'b0, q_count_q}) < DEPTH_C);
    imem_req_addr  = pc_q;
    id_valid       = reset && !redirect_valid && ((q_count_q != '0) || byp);
    q_count        = q_count_q;
    if (q_count_q != '0) begin
      id_instr = instr_mem_q[q_rd_q];
      id_npc   = npc_mem_q[q_rd_q];
    end else if (byp) begin
      id_instr = imem_resp_data;
      id_npc   = tag_mem_q[tag_rd_q] + ADDR_W'(4);
    end else begin
      id_instr = last_instr_q;
      id_npc   = last_npc_q;
    end
  end

  always_comb begin
    req_fire     = imem_req_valid && imem_req_ready;
    resp_live    = imem_resp_valid && (state_q == RUN) && !redirect_valid;
    q_push       = resp_live && !(byp && id_ready);
    q_pop        = id_valid && id_ready && (q_count_q != '0);
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    discard_d    = discard_q;
    tag_wr_d     = tag_wr_q;
    tag_rd_d     = tag_rd_q;
    q_wr_d       = q_wr_q;
    q_rd_d       = q_rd_q;
    q_count_d    = q_count_q;
    last_instr_d = id_instr;
    last_npc_d   = id_npc;
    state_d      = state_q;
    if (redirect_valid) begin
      // A response landing in the redirect cycle is dropped and leaves the discard tally.
      pc_d       = redirect_pc;
      inflight_d = '0;
      discard_d  = discard_q + DISC_W'(inflight_q) - DISC_W'(imem_resp_valid);
      tag_rd_d   = tag_wr_q;
      q_rd_d     = q_wr_q;
      q_count_d  = '0;
      state_d    = (discard_d != '0) ? DRAIN : RUN;
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + ADDR_W'(4);
        tag_wr_d = tag_wr_q + 1'b1;
      end
      if (resp_live) tag_rd_d = tag_rd_q + 1'b1;
      if (q_push) q_wr_d = q_wr_q + 1'b1;
      if (q_pop) q_rd_d = q_rd_q + 1'b1;
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_live);
      q_count_d  = q_count_q + CNT_W'(q_push) - CNT_W'(q_pop);
      case (state_q)
        RUN: state_d = RUN;
        DRAIN: begin
          if (imem_resp_valid) begin
            discard_d = discard_q - 1'b1;
            if (discard_q == DISC_W'(1)) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: queue-level reference model compared every cycle plus directed literal checks.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, imem_req_ready, imem_resp_valid, redirect_valid, id_ready;
  logic [31:0] imem_resp_data, redirect_pc;
  logic        imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_instr, id_npc;
  logic [2:0]  q_count;

  if_prefetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_npc(id_npc),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] instr; logic [31:0] npc;} ent_t;
  typedef struct {int due; logic [31:0] addr;} mreq_t;

  ent_t        mq[$];
  logic [31:0] mtags[$];
  int          mdisc = 0;
  logic [31:0] mpc = 0, mlast_i = 0, mlast_n = 0;
  bit          armed = 0;
  mreq_t       memq[$];
  int          mem_lat = 1, cyc_n = 0;
  int          n_chk = 0, n_fail = 0;
  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_instr, obs_npc, obs_qc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    logic        byp, e_rv, e_iv, e_fire, e_pop;
    logic [31:0] e_instr, e_npc, old_pc, t;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (memq.size() > 0 && memq[0].due <= cyc_n) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(memq[0].addr);
      void'(memq.pop_front());
    end
    #2;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = reset && mq.size() == 0 && mdisc == 0 && imem_resp_valid && !redirect_valid;
`endif
    e_rv = reset && !redirect_valid && (mtags.size() + mq.size() < DEPTH);
    e_iv = reset && !redirect_valid && (mq.size() > 0 || byp);
    if (mq.size() > 0) begin
      e_instr = mq[0].instr; e_npc = mq[0].npc;
    end else if (byp) begin
      e_instr = imem_resp_data; e_npc = mtags[0] + 32'd4;
    end else begin
      e_instr = mlast_i; e_npc = mlast_n;
    end
    obs_rv = imem_req_valid; obs_addr = imem_req_addr; obs_iv = id_valid;
    obs_instr = id_instr; obs_npc = id_npc; obs_qc = 32'(q_count);
    if (armed) begin
      chk("imem_req_valid", 32'(obs_rv), 32'(e_rv));
      chk("imem_req_addr", obs_addr, mpc);
      chk("id_valid", 32'(obs_iv), 32'(e_iv));
      chk("id_instr", obs_instr, e_instr);
      chk("id_npc", obs_npc, e_npc);
      chk("q_count", obs_qc, 32'(mq.size()));
    end
    e_fire = e_rv && imem_req_ready;
    e_pop  = e_iv && id_ready;
    old_pc = mpc;
    @(posedge clk);
    if (!reset) begin
      armed = 1; mpc = 0; mq.delete(); mtags.delete(); mdisc = 0;
      mlast_i = 0; mlast_n = 0; memq.delete();
    end else begin
      mlast_i = e_instr; mlast_n = e_npc;
      if (redirect_valid) begin
        mdisc = mdisc + mtags.size() - (imem_resp_valid ? 1 : 0);
        mq.delete(); mtags.delete(); mpc = redirect_pc;
      end else begin
        if (e_pop && mq.size() > 0) void'(mq.pop_front());
        if (imem_resp_valid) begin
          if (mdisc > 0) mdisc--;
          else begin
            t = mtags.pop_front();
            if (!(byp && id_ready)) mq.push_back('{instr: imem_resp_data, npc: t + 32'd4});
          end
        end
        if (e_fire) begin
          mtags.push_back(mpc);
          mpc = mpc + 32'd4;
          memq.push_back('{due: cyc_n + mem_lat, addr: old_pc});
        end
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; cyc(); cyc(); reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_iv, acc, ndel, first_npc, first_instr;
    logic [31:0] dl[$];
    reset = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;

    // 1: cold start, latency 1
    do_reset();
    first_iv = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c <= 3) begin
        chk("t1_addr", obs_addr, 32'(4 * (c - 1)));
        chk("t1_req_valid", 32'(obs_rv), 32'd1);
      end
      if (first_iv == 0 && obs_iv) begin
        first_iv = c;
        chk("t1_first_npc", obs_npc, 32'h4);
      end
    end
`ifdef IFQ_BYPASS_EN
    chk("t1_first_valid_cycle", 32'(first_iv), 32'd2);
`else
    chk("t1_first_valid_cycle", 32'(first_iv), 32'd3);
`endif

    // 2: ID stalled for 10 cycles
    do_reset();
    id_ready = 1'b0; acc = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (obs_rv && imem_req_ready) acc++;
    end
    chk("t2_accepted", 32'(acc), 32'd4);
    chk("t2_q_count", obs_qc, 32'd4);
    chk("t2_req_valid", 32'(obs_rv), 32'd0);
    id_ready = 1'b1; ndel = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (obs_iv) begin
        if (ndel < 4) begin
          chk("t2_npc", obs_npc, 32'(4 * (ndel + 1)));
          chk("t2_instr", obs_instr, memf(32'(4 * ndel)));
        end
        ndel++;
      end
    end
    chk("t2_delivered4", 32'(ndel >= 4), 32'd1);

    // 3: redirect with two requests in flight, latency 3
    do_reset();
    mem_lat = 3;
    cyc(); cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    chk("t3_redirect_req_valid", 32'(obs_rv), 32'd0);
    redirect_valid = 1'b0;
    first_npc = -1; first_instr = 0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      if (obs_iv && first_npc < 0) begin
        first_npc = int'(obs_npc); first_instr = int'(obs_instr);
      end
    end
    chk("t3_first_npc", 32'(first_npc), 32'h44);
    chk("t3_first_instr", 32'(first_instr), memf(32'h40));

    // 4: response, pop and redirect in one cycle
    do_reset();
    mem_lat = 1;
    for (int c = 0; c < 5; c++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
`ifdef IFQ_BYPASS_EN
    chk("t4_q_before", obs_qc, 32'd0);
`else
    chk("t4_q_before", obs_qc, 32'd1);
`endif
    chk("t4_no_pop", 32'(obs_iv), 32'd0);
    redirect_valid = 1'b0;
    cyc();
    chk("t4_q_after", obs_qc, 32'd0);
    chk("t4_addr", obs_addr, 32'h100);
    chk("t4_req_valid", 32'(obs_rv), 32'd1);

    // 5: PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    dl.delete();
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) chk("t5_addr0", obs_addr, 32'hFFFF_FFFC);
      if (c == 1) chk("t5_addr1", obs_addr, 32'h0);
      if (obs_iv) dl.push_back(obs_npc);
    end
    chk("t5_ndel", 32'(dl.size() >= 2), 32'd1);
    if (dl.size() >= 2) begin
      chk("t5_npc0", dl[0], 32'h0);
      chk("t5_npc1", dl[1], 32'h4);
    end

    // 6: reset mid-operation with words queued and in flight
    do_reset();
    mem_lat = 3; id_ready = 1'b0;
    for (int c = 0; c < 5; c++) cyc();
    reset = 1'b0;
    cyc();
    chk("t6_q_before", obs_qc, 32'd2);
    cyc();
    chk("t6_req_valid", 32'(obs_rv), 32'd0);
    chk("t6_addr", obs_addr, 32'h0);
    chk("t6_id_valid", 32'(obs_iv), 32'd0);
    chk("t6_instr", obs_instr, 32'h0);
    chk("t6_npc", obs_npc, 32'h0);
    chk("t6_q_count", obs_qc, 32'd0);
    reset = 1'b1; id_ready = 1'b1;
    first_npc = -1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (obs_iv && first_npc < 0) first_npc = int'(obs_npc);
    end
    chk("t6_first_npc", 32'(first_npc), 32'h4);

    // 7: mixed back-pressure and redirects, model-checked every cycle
    do_reset();
    mem_lat = 2;
    for (int c = 0; c < 300; c++) begin
      if (c == 150) mem_lat = 4;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      cyc();
    end
    imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    for (int c = 0; c < 20; c++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
